wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master, one-slave Wishbone arbiter for the 8-bit SPI/RAM bus. It shares `wb_ram` between the SPI bridge `spi_ctrl` (master 0) and the MIDI routing engine (master 1). It uses round-robin grant, holds each grant for one transfer, and enforces a bus timeout. Slave-side signals are driven low when no master is granted, so peripherals never contend on the shared bus.

## Interface

Parameters:
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.
- `TIMEOUT`, default 15: maximum number of granted cycles without ack before an error is returned. Legal range is 1 to 255.

Ports:
- `wb_clk_i`  in  1  Single clock for the block.
- `wb_rst_i`  in  1  Reset. Asynchronous, active-low.
- `m0_addr_i` in  ADDR_W  Master 0 (SPI bridge) address.
- `m0_dat_i`  in  DATA_W  Master 0 write data.
- `m0_dat_o`  out DATA_W  Master 0 read data.
- `m0_we_i`   in  1  Master 0 write enable.
- `m0_stb_i`  in  1  Master 0 strobe (request).
- `m0_ack_o`  out 1  Master 0 acknowledge.
- `m0_err_o`  out 1  Master 0 timeout error. Pulse of 1 cycle.
- `m1_addr_i`, `m1_dat_i`, `m1_dat_o`, `m1_we_i`, `m1_stb_i`, `m1_ack_o`, `m1_err_o`: master 1 (router engine), with the same widths and meanings as master 0.
- `s_addr_o`  out ADDR_W  Slave address.
- `s_dat_o`   out DATA_W  Slave write data.
- `s_dat_i`   in  DATA_W  Slave read data.
- `s_we_o`    out 1  Slave write enable.
- `s_stb_o`   out 1  Slave strobe.
- `s_ack_i`   in  1  Slave acknowledge. May be combinational from `s_stb_o`.
- `gnt_o`     out 2  One-hot current grant. `2'b00` means idle.

## Operation

State machine states:
- `IDLE`: no grant.
- `GNT0`: master 0 granted.
- `GNT1`: master 1 granted.

Registered state:
- State register.
- `last` (the index of the most recently granted master). Reset value is 1, so master 0 wins the first tie.
- Timeout counter `cnt`, width `$clog2(TIMEOUT+1)`.

Transitions from `IDLE`, evaluated at each clock edge:
- Only `m0_stb_i` is high: go to `GNT0`.
- Only `m1_stb_i` is high: go to `GNT1`.
- Both are high: grant the master that is not `last`.
- In all cases, `cnt` is cleared to 0 on entering a grant state.

Behaviour in `GNTx`:
- Slave signals are muxed from master x: `s_stb_o = mx_stb_i && (cnt != TIMEOUT)`.
- Acknowledge and data are returned only to master x: `mx_ack_o = s_ack_i && s_stb_o` and `mx_dat_o = s_dat_i`.
- The other master's `ack`, `err` and `dat_o` outputs are held at 0.

Exits from `GNTx`, evaluated at each clock edge:
- **Ack at the edge** (`s_ack_i && s_stb_o`): go to `IDLE` and set `last` to x.
- **Abort** (`mx_stb_i` low): go to `IDLE` and set `last` to x. No ack or err is issued.
- **Timeout** (`cnt == TIMEOUT`): `s_stb_o` is low, `mx_err_o` is high combinationally for this cycle, and the next state is `IDLE` with `last` set to x.
- **Otherwise**: `cnt` increments by 1 and saturates at `TIMEOUT`.

Bus behaviour in `IDLE`:
- `s_addr_o`, `s_dat_o`, `s_we_o` and `s_stb_o` are all 0.
- All master `ack`, `err` and `dat_o` outputs are 0.

General rules:
- Grant never changes in the middle of a transfer.
- A request that arrives while the other master is granted waits in `IDLE` arbitration.
- Starvation is impossible: when both masters request continuously, grants alternate 0, 1, 0, 1.

## Timing

- **Reset:** Asserting `wb_rst_i` low immediately forces the state to `IDLE`, `last` to 1 and `cnt` to 0. Every output is 0 while reset is held, including `gnt_o` = 00. This applies even in the middle of a transfer; the aborted transfer returns neither ack nor err.
- **Grant latency:** A request first seen high at edge N is granted after edge N. `s_stb_o` is high in cycle N+1.
- **Transfer time:** With a combinational slave ack, the master sees ack in cycle N+1 and the block returns to `IDLE` after edge N+1. The minimum transfer is therefore 2 cycles, including one arbitration bubble.
- **Back-to-back transfers:** A master holding `stb` high after its ack is re-arbitrated at the next `IDLE` edge. If the other master is also requesting, it wins that arbitration.
- **Timeout:** With no ack, `s_stb_o` is high for exactly `TIMEOUT` cycles. `err` is then high for 1 cycle, and the block is in `IDLE` on the following cycle.
- **Simultaneous events:** Ack and the timeout boundary cannot coincide, because `s_stb_o` is low when `cnt == TIMEOUT`. If `stb` drops in the same cycle as ack, no ack is issued to the master, because `mx_ack_o` requires `s_stb_o`, which follows `mx_stb_i`.

## Test plan

1. **Single write from master 0.**
   - Stimulus: `m0` writes address `8'h00`, data `8'hDE`, using `wb_ram` as the slave.
   - Required response: `gnt_o` = 01 in cycle N+1; `m0_ack_o` high for 1 cycle; a subsequent `m1` read of `8'h00` returns `8'hDE`.
2. **Simultaneous requests from reset.**
   - Stimulus: `m0` and `m1` both hold `stb` high for 4 transfers.
   - Required response: the grant sequence is 0, 1, 0, 1, and each master receives exactly 2 acks.
3. **Timeout.**
   - Stimulus: `TIMEOUT` = 15; `m1` requests with `s_ack_i` tied to 0.
   - Required response: `s_stb_o` is high for 15 cycles; `m1_err_o` is high for 1 cycle; `gnt_o` = 00 on the next cycle; `m0_err_o` never asserts.
4. **Abort.**
   - Stimulus: `m0` drops `stb` 3 cycles into a grant, with the slave ack held low.
   - Required response: return to `IDLE` with no ack and no err; `last` = 0, so on the next simultaneous request `m1` wins.
5. **Reset mid-transfer.**
   - Stimulus: assert `wb_rst_i` low 2 cycles into a `GNT1` transfer.
   - Required response: all outputs are 0 asynchronously; after release, a simultaneous request is granted to `m0` first.
6. **Non-granted master isolation.**
   - Stimulus: `m1` drives address `8'h55` and data `8'hAA` while `m0` is granted.
   - Required response: `s_addr_o` and `s_dat_o` carry `m0`'s values throughout, and `m1_ack_o` and `m1_dat_o` remain 0.

Source files
------------

// File: rtl/wb_arb2.sv
// wb_arb2: two-master round-robin Wishbone arbiter with per-grant bus timeout.
module wb_arb2 #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic              s_we_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t          state;
    logic            last;
    logic [CW-1:0]   cnt;
    logic            g0, g1, tmo, stb, ack;
    assign g0       = state == GNT0;
    assign g1       = state == GNT1;
    assign tmo      = cnt == CW'(TIMEOUT);
    assign stb      = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    assign s_stb_o  = stb & ~tmo;
    assign s_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    assign s_we_o   = (g0 & m0_we_i) | (g1 & m1_we_i);
    assign ack      = s_ack_i & s_stb_o;
    assign m0_ack_o = g0 & ack;
    assign m1_ack_o = g1 & ack;
    assign m0_err_o = g0 & m0_stb_i & tmo;
    assign m1_err_o = g1 & m1_stb_i & tmo;
    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m1_dat_o = g1 ? s_dat_i : '0;
    assign gnt_o    = {g1, g0};
    // On a tie the master that was not served last wins, so grants alternate.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (m0_stb_i && (!m1_stb_i || last))
                state <= GNT0;
            else if (m1_stb_i)
                state <= GNT1;
        end else if (ack || !stb || tmo) begin
            state <= IDLE;
            last  <= g1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: scoreboard bench for wb_arb2 with a small RAM slave model.
module tb_wb_arb2;
    logic       clk = 0, rst_n = 0, ack_en = 1, err_ok = 0;
    logic [7:0] m0_addr = 0, m0_wdat = 0, m0_rdat, m1_addr = 0, m1_wdat = 0, m1_rdat;
    logic       m0_we = 0, m0_stb = 0, m0_ack, m0_err, m1_we = 0, m1_stb = 0, m1_ack, m1_err;
    logic [7:0] s_addr, s_wdat, s_rdat;
    logic       s_we, s_stb, s_ack;
    logic [1:0] gnt;
    logic [7:0] ram [256];

    typedef struct {bit m; bit we; logic [7:0] dat;} exp_t;
    exp_t       exp_q[$];
    logic [1:0] gq[$];
    exp_t       e;
    int         n_chk = 0, n_fail = 0;

    wb_arb2 #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .m0_addr_i(m0_addr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_addr_i(m1_addr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_addr_o(s_addr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_we_o(s_we),
        .s_stb_o(s_stb), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    assign s_ack  = s_stb & ack_en;
    assign s_rdat = ram[s_addr];
    always @(posedge clk) if (s_stb && s_we && s_ack) ram[s_addr] <= s_wdat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (m0_ack && m1_ack) check("ack_both", 1, 0);
        if ((m0_err || m1_err) && !err_ok) check("err_unexp", 1, 0);
        if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) check("ack_unexp", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
                if (!e.we) check("rd_dat", m1_ack ? m1_rdat : m0_rdat, e.dat);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (m) begin m1_we = we; m1_addr = a; m1_wdat = d; end
        else   begin m0_we = we; m0_addr = a; m0_wdat = d; end
    endtask

    task automatic wait_ack(input bit m, input string tag);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = m ? m1_ack : m0_ack;
        end
        if (!got) check(tag, 0, 1);
        cyc();
    endtask

    task automatic xfer(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rd);
        exp_q.push_back('{m, we, rd});
        drive(m, we, a, d);
        if (m) m1_stb = 1; else m0_stb = 1;
        wait_ack(m, "xfer_no_ack");
        m0_stb = 0;
        m1_stb = 0;
    endtask

    task automatic race(input int n, input string tag);
        int a0 = 0, a1 = 0;
        logic [1:0] prev = 0;
        m0_stb = 1;
        m1_stb = 1;
        for (int i = 0; i < 80 && (a0 < n || a1 < n); i++) begin
            @(negedge clk);
            if (gnt != 0 && prev == 0) begin
                if (gq.size() == 0) check({tag, "_gnt_extra"}, gnt, 0);
                else check({tag, "_gnt"}, gnt, gq.pop_front());
            end
            prev = gnt;
            a0 += int'(m0_ack);
            a1 += int'(m1_ack);
            cyc();
            if (a0 == n) m0_stb = 0;
            if (a1 == n) m1_stb = 0;
        end
        check({tag, "_acks0"}, a0, n);
        check({tag, "_acks1"}, a1, n);
        check({tag, "_gnt_left"}, gq.size(), 0);
        m0_stb = 0;
        m1_stb = 0;
    endtask

    initial begin
        int sc, e0, e1;
        bit done;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        // reset: nothing granted even with a request pending
        m0_stb = 1;
        #3;
        check("rst_gnt", gnt, 0);
        check("rst_stb", s_stb, 0);
        @(posedge clk); #1;
        check("rst_hold_gnt", gnt, 0);
        check("rst_ack", m0_ack, 0);
        m0_stb = 0;
        @(negedge clk) rst_n = 1;
        cyc();

        // 1: single write from m0, then m1 reads it back
        exp_q.push_back('{0, 1, 8'h00});
        drive(0, 1, 8'h00, 8'hDE);
        m0_stb = 1;
        cyc();
        @(negedge clk);
        check("w_gnt", gnt, 2'b01);
        check("w_stb", s_stb, 1);
        check("w_addr", s_addr, 8'h00);
        check("w_dat", s_wdat, 8'hDE);
        check("w_ack", m0_ack, 1);
        cyc();
        m0_stb = 0;
        @(negedge clk);
        check("w_ack_1cyc", m0_ack, 0);
        check("w_idle", gnt, 0);
        cyc();
        xfer(1, 0, 8'h00, 8'h00, 8'hDE);

        // 2: continuous requests alternate 0,1,0,1
        drive(0, 1, 8'h10, 8'h11);
        drive(1, 1, 8'h20, 8'h22);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{bit'(i % 2), 1, 8'h00});
            gq.push_back((i % 2) ? 2'b10 : 2'b01);
        end
        race(2, "rr");
        xfer(0, 0, 8'h20, 8'h00, 8'h22);

        // 3: timeout on m1
        ack_en = 0;
        err_ok = 1;
        drive(1, 0, 8'h01, 8'h00);
        m1_stb = 1;
        sc = 0; e0 = 0; e1 = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            sc += int'(s_stb);
            e1 += int'(m1_err);
            e0 += int'(m0_err);
            done = m1_err;
        end
        cyc();
        m1_stb = 0;
        @(negedge clk);
        check("to_stb_cycles", sc, 15);
        check("to_err1", e1, 1);
        check("to_err0", e0, 0);
        check("to_err_1cyc", m1_err, 0);
        check("to_idle", gnt, 0);
        err_ok = 0;
        ack_en = 1;
        cyc();

        // 4: m0 aborts 3 cycles into its grant; m1 must win the next tie
        ack_en = 0;
        drive(0, 0, 8'h02, 8'h00);
        m0_stb = 1;
        repeat (4) cyc();
        m0_stb = 0;
        @(negedge clk);
        check("ab_stb", s_stb, 0);
        check("ab_err", m0_err, 0);
        cyc();
        @(negedge clk);
        check("ab_idle", gnt, 0);
        ack_en = 1;
        cyc();
        drive(0, 0, 8'h20, 8'h00);
        drive(1, 0, 8'h10, 8'h00);
        exp_q.push_back('{1, 0, 8'h11});
        exp_q.push_back('{0, 0, 8'h22});
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        race(1, "ab");

        // 5: reset 2 cycles into a GNT1 transfer
        ack_en = 0;
        drive(1, 0, 8'h03, 8'h00);
        m1_stb = 1;
        cyc();
        cyc();
        #2 rst_n = 0;
        #1;
        check("mr_gnt", gnt, 0);
        check("mr_stb", s_stb, 0);
        check("mr_addr", s_addr, 0);
        check("mr_ack_err", {m1_ack, m1_err}, 0);
        check("mr_dat", m1_rdat, 0);
        @(posedge clk); #1;
        check("mr_hold", gnt, 0);
        m1_stb = 0;
        @(negedge clk) rst_n = 1;
        ack_en = 1;
        cyc();
        drive(0, 0, 8'h10, 8'h00);
        drive(1, 0, 8'h20, 8'h00);
        exp_q.push_back('{0, 0, 8'h11});
        exp_q.push_back('{1, 0, 8'h22});
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        race(1, "mr");

        // 6: m1 drives the bus inputs while m0 is granted
        ack_en = 0;
        drive(0, 1, 8'h33, 8'h77);
        m0_stb = 1;
        cyc();
        drive(1, 1, 8'h55, 8'hAA);
        m1_stb = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("iso_gnt", gnt, 2'b01);
            check("iso_addr", s_addr, 8'h33);
            check("iso_dat", s_wdat, 8'h77);
            check("iso_m0_rdat", m0_rdat, 8'h69);
            check("iso_m1_ack", m1_ack, 0);
            check("iso_m1_dat", m1_rdat, 0);
            cyc();
        end
        exp_q.push_back('{0, 1, 8'h00});
        exp_q.push_back('{1, 1, 8'h00});
        ack_en = 1;
        wait_ack(0, "iso_ack0");
        m0_stb = 0;
        wait_ack(1, "iso_ack1");
        m1_stb = 0;
        xfer(0, 0, 8'h55, 8'h00, 8'hAA);
        xfer(1, 0, 8'h33, 8'h00, 8'h77);

        check("exp_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
